// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, and hands the IR to the decoder via valid/ack.
// Optional IF_HALT_OPCODE_EN: a fetched HALT_OPCODE parks the stage in HALTED instead of issuing.
module instr_fetch #(
   parameter int                   ADDR_W      = 8,
   parameter int                   INSTR_W     = 8,
   parameter logic [ADDR_W-1:0]    START_ADDR  = '0,
   parameter logic [INSTR_W-1:0]   HALT_OPCODE = '1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   input  logic               ir_ack,
   input  logic               jump_en,
   input  logic [ADDR_W-1:0]  jump_addr,
   input  logic               halt_req,
   input  logic [INSTR_W-1:0] r_instr,
   output logic [ADDR_W-1:0]  r_addr,
   output logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] ir,
   output logic               ir_valid,
   output logic               busy,
   output logic               halted
);

   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ISSUE, HALTED} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               ir_valid_q, ir_valid_d;
   logic               busy_q, busy_d;
   logic               halted_q, halted_d;
   logic               active;

   assign active = (state_q == FETCH) || (state_q == CAPTURE) || (state_q == ISSUE);

`ifndef IF_HALT_OPCODE_EN
   logic unused_halt_opcode;
   assign unused_halt_opcode = ^HALT_OPCODE;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   state_d = CAPTURE;
         CAPTURE: begin
            ir_d       = r_instr;
            ir_valid_d = 1'b1;
            state_d    = ISSUE;
`ifdef IF_HALT_OPCODE_EN
            if (r_instr == HALT_OPCODE) begin
               ir_valid_d = 1'b0;
               state_d    = HALTED;
            end
`endif
         end
         ISSUE: begin
            if (ir_ack && !stall) begin
               ir_valid_d = 1'b0;
               pc_d       = jump_en ? jump_addr : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               state_d    = FETCH;
            end
         end
         HALTED: begin
            if (start) begin
               pc_d    = START_ADDR;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
      // halt_req overrides anything decided above, including a same-cycle ack/jump or capture
      if (halt_req && active) begin
         state_d    = HALTED;
         pc_d       = pc_q;
         ir_d       = ir_q;
         ir_valid_d = 1'b0;
      end
      busy_d   = (state_d == FETCH) || (state_d == CAPTURE) || (state_d == ISSUE);
      halted_d = (state_d == HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= START_ADDR;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
      end
   end

   assign pc       = pc_q;
   assign r_addr   = pc_q;
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign busy     = busy_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle synchronous instruction memory model.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst_n, start, stall, ir_ack, jump_en, halt_req;
   logic [7:0] jump_addr, r_instr, r_addr, pc, ir;
   logic       ir_valid, busy, halted;
   logic [7:0] mem [256];
   int         checks = 0;
   int         errors = 0;

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .ir_ack(ir_ack),
      .jump_en(jump_en), .jump_addr(jump_addr), .halt_req(halt_req), .r_instr(r_instr),
      .r_addr(r_addr), .pc(pc), .ir(ir), .ir_valid(ir_valid), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;
   always @(posedge clk) r_instr <= mem[r_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      mem[4] = 8'h55; mem[5] = 8'h66; mem[8'h80] = 8'hA5; mem[8'hFF] = 8'h5A;
   endtask

   // reset, then accept start; leaves the DUT in FETCH at START_ADDR
   task automatic restart();
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; ir_ack = 1'b0;
      jump_en = 1'b0; jump_addr = 8'h00; halt_req = 1'b0;
      tick();
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; ir_ack = 1'b0;
      jump_en = 1'b0; jump_addr = 8'h00; halt_req = 1'b0;
      #3;
      checks++;
      if ({pc, ir, ir_valid, busy, halted} !== {8'h00, 8'h00, 3'b000}) begin
         errors++;
         $display("FAIL reset: pc=%h ir=%h v=%b busy=%b halted=%b, required 00 00 0 0 0",
                  pc, ir, ir_valid, busy, halted);
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({busy, halted} !== 2'b00) begin
         errors++; $display("FAIL idle_no_start: busy=%b halted=%b, required 0 0", busy, halted);
      end
   endtask

   task automatic test_stream();
      logic [7:0] exp [4];
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
      restart();
      ir_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({r_addr, busy, ir_valid} !== {8'(i), 2'b10}) begin
            errors++;
            $display("FAIL stream_fetch%0d: r_addr=%h busy=%b v=%b, required %h 1 0", i, r_addr, busy, ir_valid, 8'(i));
         end
         tick();
         checks++;
         if (ir_valid !== 1'b0) begin
            errors++; $display("FAIL stream_capture%0d: v=%b, required 0", i, ir_valid);
         end
         tick();
         checks++;
         if ({ir_valid, ir} !== {1'b1, exp[i]}) begin
            errors++; $display("FAIL stream_issue%0d: v=%b ir=%h, required 1 %h", i, ir_valid, ir, exp[i]);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      restart();
      ir_ack = 1'b1;
      tick(); tick(); tick();  // issue mem[0]
      tick();
      stall = 1'b1;
      tick();                  // ISSUE with ir=22
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({ir_valid, ir, pc, r_addr} !== {1'b1, 8'h22, 8'h01, 8'h01}) begin
            errors++;
            $display("FAIL stall%0d: v=%b ir=%h pc=%h r_addr=%h, required 1 22 01 01", i, ir_valid, ir, pc, r_addr);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if ({ir_valid, pc} !== {1'b0, 8'h02}) begin
         errors++; $display("FAIL stall_release: v=%b pc=%h, required 0 02", ir_valid, pc);
      end
   endtask

   task automatic test_jump();
      restart();
      ir_ack = 1'b1; jump_en = 1'b1; jump_addr = 8'h80;
      tick(); tick(); tick();
      checks++;
      if (r_addr !== 8'h80) begin
         errors++; $display("FAIL jump_addr: r_addr=%h, required 80", r_addr);
      end
      jump_addr = 8'hFF;
      tick(); tick();
      checks++;
      if ({ir_valid, ir} !== {1'b1, 8'hA5}) begin
         errors++; $display("FAIL jump_ir: v=%b ir=%h, required 1 a5", ir_valid, ir);
      end
      tick();
      jump_en = 1'b0;
      tick(); tick();
      checks++;
      if ({pc, ir} !== {8'hFF, 8'h5A}) begin
         errors++; $display("FAIL jump_ff: pc=%h ir=%h, required ff 5a", pc, ir);
      end
      tick();
      checks++;
      if (pc !== 8'h00) begin
         errors++; $display("FAIL pc_wrap: pc=%h, required 00", pc);
      end
   endtask

   task automatic test_halt();
      restart();
      ir_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(); tick(); tick();
      end
      ir_ack = 1'b0;
      tick(); tick();
      checks++;
      if ({pc, ir, ir_valid} !== {8'h05, 8'h66, 1'b1}) begin
         errors++; $display("FAIL halt_setup: pc=%h ir=%h v=%b, required 05 66 1", pc, ir, ir_valid);
      end
      ir_ack = 1'b1; halt_req = 1'b1; jump_en = 1'b1; jump_addr = 8'h40; start = 1'b1;
      tick();
      ir_ack = 1'b0; halt_req = 1'b0; jump_en = 1'b0; start = 1'b0;
      checks++;
      if ({halted, busy, ir_valid, pc} !== {3'b100, 8'h05}) begin
         errors++;
         $display("FAIL halt: halted=%b busy=%b v=%b pc=%h, required 1 0 0 05", halted, busy, ir_valid, pc);
      end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      checks++;
      if ({halted, pc} !== {1'b1, 8'h05}) begin
         errors++; $display("FAIL halt_hold: halted=%b pc=%h, required 1 05", halted, pc);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({pc, busy, halted} !== {8'h00, 2'b10}) begin
         errors++; $display("FAIL restart: pc=%h busy=%b halted=%b, required 00 1 0", pc, busy, halted);
      end
      tick(); tick();
      checks++;
      if ({ir_valid, ir} !== {1'b1, 8'h11}) begin
         errors++; $display("FAIL restart_ir: v=%b ir=%h, required 1 11", ir_valid, ir);
      end
   endtask

   task automatic test_async_reset();
      restart();
      ir_ack = 1'b1;
      tick(); tick(); tick();
      tick();                  // CAPTURE of mem[1], ir still 11
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({pc, ir, ir_valid, busy, halted} !== {8'h00, 8'h00, 3'b000}) begin
         errors++;
         $display("FAIL async_reset: pc=%h ir=%h v=%b busy=%b halted=%b, required 00 00 0 0 0",
                  pc, ir, ir_valid, busy, halted);
      end
      tick();
      rst_n = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      checks++;
      if ({pc, ir, ir_valid} !== {8'h00, 8'h11, 1'b1}) begin
         errors++; $display("FAIL reset_resume: pc=%h ir=%h v=%b, required 00 11 1", pc, ir, ir_valid);
      end
   endtask

   task automatic test_halt_opcode();
      mem[2] = 8'hFF;
      restart();
      ir_ack = 1'b1;
      tick(); tick(); tick();
      tick(); tick(); tick();
      tick(); tick();
`ifdef IF_HALT_OPCODE_EN
      checks++;
      if ({halted, busy, ir_valid, pc, ir} !== {3'b100, 8'h02, 8'hFF}) begin
         errors++;
         $display("FAIL halt_opcode: halted=%b busy=%b v=%b pc=%h ir=%h, required 1 0 0 02 ff",
                  halted, busy, ir_valid, pc, ir);
      end
`else
      checks++;
      if ({halted, busy, ir_valid, pc, ir} !== {3'b011, 8'h02, 8'hFF}) begin
         errors++;
         $display("FAIL ff_issued: halted=%b busy=%b v=%b pc=%h ir=%h, required 0 1 1 02 ff",
                  halted, busy, ir_valid, pc, ir);
      end
`endif
      mem[2] = 8'h33;
   endtask

   initial begin
      init_mem();
      test_reset();
      test_stream();
      test_stall();
      test_jump();
      test_halt();
      test_async_reset();
      test_halt_opcode();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
